// File: rtl/hazard_scheduler_if.sv
// Decoder-side hazard bus: ID-stage instruction fields in, pipeline control and debug counters out.
interface hazard_scheduler_if #(
  parameter int unsigned CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_en;
  logic             id_memtoreg;
  logic             ex_branch_taken;
  logic             stall_if;
  logic             bubble_ex;
  logic             flush_ifid;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_reg_en, id_memtoreg, ex_branch_taken,
    input  stall_if, bubble_ex, flush_ifid, fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs2, id_rd, id_reg_en, id_memtoreg, ex_branch_taken,
    output stall_if, bubble_ex, flush_ifid, fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_scheduler.sv
// RV32I 5-stage hazard controller: shadow EX/MEM/WB scoreboard, load-use stall,
// redirect flush sequencing, EX operand forwarding selects and saturating event counters.
module hazard_scheduler #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  hazard_scheduler_if.slave bus
);
  typedef enum logic {RUN, FLUSH} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       reg_en;
    logic       memtoreg;
  } slot_t;

  localparam logic [2:0] FCNT_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t           state;
  logic [2:0]       fcnt;
  slot_t            ex_slot, mem_slot, wb_slot;
  logic [4:0]       ex_rs1, ex_rs2;
  logic             ex_uses_rs2;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic       load_use, in_flush, redirect;
  logic       stall, bubble, flush;
  logic [1:0] sel_a, sel_b;

  function automatic logic live(input slot_t s);
    return s.valid && s.reg_en && (s.rd != 5'd0);
  endfunction

  // MEM is checked first so the youngest writer wins; a MEM load never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input slot_t m, input slot_t w);
    if (live(m) && !m.memtoreg && (m.rd == rs)) return 2'b10;
    if (live(w) && (w.rd == rs)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    load_use = bus.id_valid && live(ex_slot) && ex_slot.memtoreg &&
               ((ex_slot.rd == bus.id_rs1) || (bus.id_uses_rs2 && (ex_slot.rd == bus.id_rs2)));
    in_flush = (state == FLUSH);
    redirect = !in_flush && bus.ex_branch_taken;
    stall    = 1'b0;
    bubble   = 1'b0;
    flush    = 1'b0;
    sel_a    = 2'b00;
    sel_b    = 2'b00;
    if (!reset) begin
      flush  = in_flush || redirect;
      bubble = in_flush || redirect || load_use;
      stall  = !in_flush && !redirect && load_use;
      if (ex_slot.valid) begin
        sel_a = fwd_sel(ex_rs1, mem_slot, wb_slot);
        if (ex_uses_rs2) sel_b = fwd_sel(ex_rs2, mem_slot, wb_slot);
      end
    end
  end

  assign bus.stall_if    = stall;
  assign bus.bubble_ex   = bubble;
  assign bus.flush_ifid  = flush;
  assign bus.fwd_a       = sel_a;
  assign bus.fwd_b       = sel_b;
  assign bus.stall_count = stall_cnt;
  assign bus.flush_count = flush_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      fcnt        <= '0;
      ex_slot     <= '0;
      mem_slot    <= '0;
      wb_slot     <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_uses_rs2 <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      wb_slot     <= mem_slot;
      mem_slot    <= ex_slot;
      ex_slot     <= '{valid: bus.id_valid && !bubble, rd: bus.id_rd,
                       reg_en: bus.id_reg_en, memtoreg: bus.id_memtoreg};
      ex_rs1      <= bus.id_rs1;
      ex_rs2      <= bus.id_rs2;
      ex_uses_rs2 <= bus.id_uses_rs2;

      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redirect && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);

      // fcnt holds the FLUSH cycles still owed; leaving on the last one makes the
      // redirect cycle plus FLUSH-state cycles total exactly FLUSH_CYCLES.
      case (state)
        RUN: begin
          if (redirect) begin
            fcnt <= FCNT_LOAD;
            if (FLUSH_CYCLES > 1) state <= FLUSH;
          end
        end
        FLUSH: begin
          fcnt <= fcnt - 3'd1;
          if (fcnt <= 3'd1) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_scheduler.sv
// Scoreboard bench for hazard_scheduler: directed instruction streams push expected
// control outputs; a negedge monitor pops and compares them.
module tb_hazard_scheduler;
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses;
    logic [4:0] rd;
    logic       reg_en;
    logic       mem;
  } instr_t;

  typedef struct {
    bit          sel;
    string       name;
    logic [38:0] val;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  hazard_scheduler_if #(.CNT_W(16)) bus ();
  hazard_scheduler_if #(.CNT_W(3))  sbus ();

  hazard_scheduler #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (.clock(clock), .reset(reset), .bus(bus));
  hazard_scheduler #(.FLUSH_CYCLES(1), .CNT_W(3))  dut_small (.clock(clock), .reset(reset), .bus(sbus));

  initial forever #5 clock = ~clock;

  function automatic instr_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u, input logic [4:0] rd, input logic re, input logic me);
    instr_t i;
    i.valid = v; i.rs1 = rs1; i.rs2 = rs2; i.uses = u; i.rd = rd; i.reg_en = re; i.mem = me;
    return i;
  endfunction

  function automatic logic [38:0] E(input logic st, input logic bu, input logic fl,
                                    input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
    return {st, bu, fl, fa, fb, 16'(sc), 16'(fc)};
  endfunction

  task automatic drive(input bit sel, input instr_t i, input logic br);
    if (sel) begin
      sbus.id_valid = i.valid; sbus.id_rs1 = i.rs1; sbus.id_rs2 = i.rs2; sbus.id_uses_rs2 = i.uses;
      sbus.id_rd = i.rd; sbus.id_reg_en = i.reg_en; sbus.id_memtoreg = i.mem; sbus.ex_branch_taken = br;
    end else begin
      bus.id_valid = i.valid; bus.id_rs1 = i.rs1; bus.id_rs2 = i.rs2; bus.id_uses_rs2 = i.uses;
      bus.id_rd = i.rd; bus.id_reg_en = i.reg_en; bus.id_memtoreg = i.mem; bus.ex_branch_taken = br;
    end
  endtask

  task automatic push(input bit sel, input string name, input logic [38:0] e);
    exp_t x;
    x.sel = sel; x.name = name; x.val = e;
    sb.push_back(x);
  endtask

  task automatic step(input bit sel, input string name, input instr_t i, input logic br, input logic [38:0] e);
    drive(sel, i, br);
    push(sel, name, e);
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    drive(1'b0, '0, 1'b0);
    drive(1'b1, '0, 1'b0);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  // Monitor: samples 1 time unit after each falling clock edge, or right after reset rises.
  initial begin
    exp_t e;
    logic [38:0] act;
    forever begin
      @(negedge clock or posedge reset);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        if (e.sel)
          act = {sbus.stall_if, sbus.bubble_ex, sbus.flush_ifid, sbus.fwd_a, sbus.fwd_b,
                 13'd0, sbus.stall_count, 13'd0, sbus.flush_count};
        else
          act = {bus.stall_if, bus.bubble_ex, bus.flush_ifid, bus.fwd_a, bus.fwd_b,
                 bus.stall_count, bus.flush_count};
        checks++;
        if (act !== e.val) begin
          failures++;
          $display("FAIL %s: got st=%b bu=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d, want st=%b bu=%b fl=%b fa=%b fb=%b sc=%0d fc=%0d",
                   e.name, act[38], act[37], act[36], act[35:34], act[33:32], act[31:16], act[15:0],
                   e.val[38], e.val[37], e.val[36], e.val[35:34], e.val[33:32], e.val[31:16], e.val[15:0]);
        end
      end
    end
  end

  initial begin
    instr_t NOP, LW5, ADD6, A3, B3, C4, A0, B0, C0, LW8, ADD9, LW55;
    logic odd;
    int   sc;
    NOP  = '0;
    LW5  = mk(1'b1, 5'd1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);  // lw   x5, 0(x1)
    ADD6 = mk(1'b1, 5'd5, 5'd7, 1'b1, 5'd6, 1'b1, 1'b0);  // add  x6, x5, x7
    A3   = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);  // addi x3, x0, 1
    B3   = mk(1'b1, 5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);  // addi x3, x3, 1
    C4   = mk(1'b1, 5'd3, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);  // add  x4, x3, x3
    A0   = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // addi x0, x0, 1
    B0   = mk(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);  // addi x0, x0, 1
    C0   = mk(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0);  // add  x4, x0, x0
    LW8  = mk(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);  // lw   x8, 0(x1)
    ADD9 = mk(1'b1, 5'd8, 5'd2, 1'b1, 5'd9, 1'b1, 1'b0);  // add  x9, x8, x2
    LW55 = mk(1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);  // lw   x5, 0(x5)

    drive(1'b0, NOP, 1'b0);
    drive(1'b1, NOP, 1'b0);
    #2;
    push(1'b0, "reset_state", E(0, 0, 0, 2'b00, 2'b00, 0, 0));
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;

    // Load-use: one stall, then WB forward of the load into EX
    step(0, "lu_load",    LW5,  0, E(0, 0, 0, 2'b00, 2'b00, 0, 0));
    step(0, "lu_stall",   ADD6, 0, E(1, 1, 0, 2'b00, 2'b00, 0, 0));
    step(0, "lu_release", ADD6, 0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "lu_fwd_wb",  NOP,  0, E(0, 0, 0, 2'b01, 2'b00, 1, 0));
    step(0, "lu_drain0",  NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "lu_drain1",  NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));

    // Back-to-back writers of x3: MEM beats WB on both operands
    step(0, "fw_a",       A3,   0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "fw_b",       B3,   0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "fw_mem_a",   C4,   0, E(0, 0, 0, 2'b10, 2'b00, 1, 0));
    step(0, "fw_prio",    NOP,  0, E(0, 0, 0, 2'b10, 2'b10, 1, 0));
    step(0, "fw_drain0",  NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "fw_drain1",  NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));

    // Same sequence targeting x0: never forwards
    step(0, "x0_a",       A0,   0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "x0_b",       B0,   0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "x0_c",       C0,   0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "x0_nofwd",   NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "x0_drain0",  NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));
    step(0, "x0_drain1",  NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 0));

    // Taken branch: two flush cycles, second pulse inside flush ignored
    step(0, "br_take",    NOP,  1, E(0, 1, 1, 2'b00, 2'b00, 1, 0));
    step(0, "br_flush2",  NOP,  1, E(0, 1, 1, 2'b00, 2'b00, 1, 1));
    step(0, "br_run",     NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 1));
    step(0, "br_hold",    NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 1));

    // Load-use coinciding with redirect: redirect wins, no stall counted
    step(0, "sim_load",   LW8,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 1));
    step(0, "sim_both",   ADD9, 1, E(0, 1, 1, 2'b00, 2'b00, 1, 1));
    step(0, "sim_flush2", ADD9, 0, E(0, 1, 1, 2'b00, 2'b00, 1, 2));
    step(0, "sim_run",    NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 2));
    step(0, "sim_hold",   NOP,  0, E(0, 0, 0, 2'b00, 2'b00, 1, 2));

    // Saturation on the 3-bit instance: self-dependent load stalls every other cycle
    for (int k = 0; k < 22; k++) begin
      odd = (k % 2) == 1;
      sc  = (k / 2 > 7) ? 7 : k / 2;
      step(1, "sat_stall", LW55, 0, E(odd, odd, 0, (odd && k >= 3) ? 2'b01 : 2'b00, 2'b00, sc, 0));
    end
    idle(3);
    // FLUSH_CYCLES = 1: flush only in the redirect cycle itself
    step(1, "f1_take",  NOP, 1, E(0, 1, 1, 2'b00, 2'b00, 7, 0));
    step(1, "f1_done",  NOP, 0, E(0, 0, 0, 2'b00, 2'b00, 7, 1));

    // Reset asserted in the second flush cycle, between clock edges
    step(0, "rst_take", NOP, 1, E(0, 1, 1, 2'b00, 2'b00, 1, 2));
    drive(0, NOP, 0);
    push(0, "rst_flush2", E(0, 1, 1, 2'b00, 2'b00, 1, 3));
    #6;
    push(0, "rst_async", E(0, 0, 0, 2'b00, 2'b00, 0, 0));
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    step(0, "post_rst0", NOP, 0, E(0, 0, 0, 2'b00, 2'b00, 0, 0));
    step(0, "post_rst1", NOP, 0, E(0, 0, 0, 2'b00, 2'b00, 0, 0));
    step(0, "post_rst2", NOP, 0, E(0, 0, 0, 2'b00, 2'b00, 0, 0));

    repeat (2) @(posedge clock);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
